mskaes_unshare_sink: RTL and testbench

Output-side responder for the masked AES-128 core: accepts the bit-interleaved shared ciphertext on the core's `cipher_valid` strobe, recombines the `d` shares one share per cycle in a registered accumulator, and streams the unmasked 128-bit ciphertext out as four 32-bit words over a valid/ready handshake. It is the consumer that sits after the `wrapper_aes128` output port and replaces ad-hoc XOR recombination at the system boundary. Share registers are zeroized once consumed.

---
 rtl/mskaes_unshare_sink.sv | 130 +++++++++++++
 tb/tb_mskaes_unshare_sink.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mskaes_unshare_sink.sv
// Output-side unmasking sink for the masked AES-128 core: captures one shared ciphertext,
// folds one share per cycle into an accumulator, then streams four 32-bit words out.
module mskaes_unshare_sink #(
    parameter int d = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cipher_valid,
    input  logic [128*d-1:0] sh_ciphertext,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [1:0]       out_idx,
    output logic             out_last,
    output logic [7:0]       drop_cnt
);
    localparam int JW = (d > 1) ? $clog2(d) : 1;
    localparam logic [JW-1:0] LAST_J = JW'(d - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        SEND
    } state_t;

    state_t           r_state;
    logic [128*d-1:0] r_shareReg;
    logic [127:0]     r_acc;
    logic [JW-1:0]    r_j;
    logic [1:0]       r_k;
    logic             r_inReady;
    logic             r_outValid;
    logic [31:0]      r_outData;
    logic             r_outLast;
    logic [7:0]       r_dropCnt;

    logic [127:0]     w_shareSlice;
    logic [127:0]     w_accNext;
    logic [1:0]       w_kNext;
    logic [31:0]      w_nextWord;

    // Share j of every bit sits at stride d; constant indices keep the select in range for any d.
    always_comb begin
        w_shareSlice = '0;
        for (int i = 0; i < 128; i++) begin
            for (int jj = 0; jj < d; jj++) begin
                if (r_j == JW'(jj)) begin
                    w_shareSlice[i] = r_shareReg[d*i + jj];
                end
            end
        end
    end

    assign w_accNext  = r_acc ^ w_shareSlice;
    assign w_kNext    = r_k + 2'd1;
    assign w_nextWord = r_acc[{w_kNext, 5'd0} +: 32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shareReg <= '0;
            r_acc      <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outLast  <= 1'b0;
            r_dropCnt  <= '0;
        end else begin
            if (cipher_valid && (r_state != IDLE) && (r_dropCnt != 8'hFF)) begin
                r_dropCnt <= r_dropCnt + 8'd1;
            end
            case (r_state)
                IDLE: begin
                    if (cipher_valid) begin
                        r_shareReg <= sh_ciphertext;
                        r_acc      <= '0;
                        r_j        <= '0;
                        r_inReady  <= 1'b0;
                        r_state    <= ACC;
                    end
                end
                ACC: begin
                    r_acc <= w_accNext;
                    // Word 0 is taken from the final fold so out_data is valid the cycle SEND starts.
                    if (r_j == LAST_J) begin
                        r_shareReg <= '0;
                        r_k        <= '0;
                        r_outValid <= 1'b1;
                        r_outData  <= w_accNext[31:0];
                        r_outLast  <= 1'b0;
                        r_state    <= SEND;
                    end else begin
                        r_j <= r_j + JW'(1);
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (r_k == 2'd3) begin
                            r_acc      <= '0;
                            r_k        <= '0;
                            r_outValid <= 1'b0;
                            r_outData  <= '0;
                            r_outLast  <= 1'b0;
                            r_inReady  <= 1'b1;
                            r_state    <= IDLE;
                        end else begin
                            r_k       <= w_kNext;
                            r_outData <= w_nextWord;
                            r_outLast <= (w_kNext == 2'd3);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_inReady;
    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign out_idx   = r_k;
    assign out_last  = r_outLast;
    assign drop_cnt  = r_dropCnt;

endmodule

// File: tb/tb_mskaes_unshare_sink.sv
// Directed bench for mskaes_unshare_sink: a d=2 and a d=3 instance share clock, reset and out_ready.
module tb_mskaes_unshare_sink;
    localparam logic [127:0] C = 128'h2e2b34ca59fa4c883b2c8aefd44be966;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic outReady = 1'b0;
    logic cv2 = 1'b0;
    logic cv3 = 1'b0;
    logic [255:0] sh2 = '0;
    logic [383:0] sh3 = '0;

    logic inReady2, outValid2, outLast2;
    logic [31:0] outData2;
    logic [1:0] outIdx2;
    logic [7:0] dropCnt2;
    logic inReady3, outValid3, outLast3;
    logic [31:0] outData3;
    logic [1:0] outIdx3;
    logic [7:0] dropCnt3;

    int nChecks = 0;
    int nPass = 0;

    logic [31:0] cWords [4] = '{32'hd44be966, 32'h3b2c8aef, 32'h59fa4c88, 32'h2e2b34ca};
    logic [31:0] rxData [8];
    logic [1:0]  rxIdx [8];
    logic        rxLast [8];
    int          rxCount;
    logic        rxHoldBad;

    logic        sel3 = 1'b0;
    logic        obsValid, obsLast;
    logic [31:0] obsData;
    logic [1:0]  obsIdx;

    assign obsValid = sel3 ? outValid3 : outValid2;
    assign obsLast  = sel3 ? outLast3  : outLast2;
    assign obsData  = sel3 ? outData3  : outData2;
    assign obsIdx   = sel3 ? outIdx3   : outIdx2;

    mskaes_unshare_sink #(.d(2)) dut2 (
        .clk(clk), .rst(rst), .cipher_valid(cv2), .sh_ciphertext(sh2),
        .in_ready(inReady2), .out_valid(outValid2), .out_ready(outReady),
        .out_data(outData2), .out_idx(outIdx2), .out_last(outLast2), .drop_cnt(dropCnt2)
    );

    mskaes_unshare_sink #(.d(3)) dut3 (
        .clk(clk), .rst(rst), .cipher_valid(cv3), .sh_ciphertext(sh3),
        .in_ready(inReady3), .out_valid(outValid3), .out_ready(outReady),
        .out_data(outData3), .out_idx(outIdx3), .out_last(outLast3), .drop_cnt(dropCnt3)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] pack2(input logic [127:0] a, input logic [127:0] b);
        logic [255:0] v;
        for (int i = 0; i < 128; i++) begin
            v[2*i]     = a[i];
            v[2*i + 1] = b[i];
        end
        return v;
    endfunction

    function automatic logic [383:0] pack3(input logic [127:0] a, input logic [127:0] b,
                                           input logic [127:0] c);
        logic [383:0] v;
        for (int i = 0; i < 128; i++) begin
            v[3*i]     = a[i];
            v[3*i + 1] = b[i];
            v[3*i + 2] = c[i];
        end
        return v;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Collects up to four beats from the selected instance, optionally stalling while word stallIdx is shown.
    task automatic recv(input int stallIdx, input int stallCycles);
        int stalls;
        logic [31:0] held;
        logic pendingHold;
        stalls = stallCycles;
        held = '0;
        pendingHold = 1'b0;
        rxCount = 0;
        rxHoldBad = 1'b0;
        for (int c = 0; c < 40 && rxCount < 4; c++) begin
            if (c > 0) @(negedge clk);
            if (pendingHold && (obsValid !== 1'b1 || obsIdx !== 2'(stallIdx) || obsData !== held))
                rxHoldBad = 1'b1;
            pendingHold = 1'b0;
            if (obsValid === 1'b1) begin
                if (obsIdx == 2'(stallIdx) && stalls > 0) begin
                    held = obsData;
                    outReady = 1'b0;
                    stalls--;
                    pendingHold = 1'b1;
                end else begin
                    outReady = 1'b1;
                    rxData[rxCount] = obsData;
                    rxIdx[rxCount] = obsIdx;
                    rxLast[rxCount] = obsLast;
                    rxCount++;
                end
            end else begin
                outReady = 1'b1;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        nChecks++; if (inReady2 !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b want 1", inReady2); else nPass++;
        nChecks++; if (outValid2 !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b want 0", outValid2); else nPass++;
        nChecks++; if (outData2 !== 32'h0) $display("[TB] FAIL reset_out_data: got %h want 0", outData2); else nPass++;
        nChecks++; if (outIdx2 !== 2'd0) $display("[TB] FAIL reset_out_idx: got %0d want 0", outIdx2); else nPass++;
        nChecks++; if (outLast2 !== 1'b0) $display("[TB] FAIL reset_out_last: got %b want 0", outLast2); else nPass++;
        nChecks++; if (dropCnt2 !== 8'd0) $display("[TB] FAIL reset_drop_cnt: got %0d want 0", dropCnt2); else nPass++;
        nChecks++; if (inReady3 !== 1'b1 || outValid3 !== 1'b0) $display("[TB] FAIL reset_d3: got rdy=%b vld=%b want 1/0", inReady3, outValid3); else nPass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [127:0] r;
        r = rand128();
        sel3 = 1'b0;
        outReady = 1'b1;
        sh2 = pack2(r, r ^ C);
        cv2 = 1'b1;
        @(negedge clk);
        cv2 = 1'b0;
        nChecks++; if (inReady2 !== 1'b0) $display("[TB] FAIL basic_busy_in_ready: got %b want 0", inReady2); else nPass++;
        nChecks++; if (outValid2 !== 1'b0) $display("[TB] FAIL basic_valid_e0: got %b want 0", outValid2); else nPass++;
        @(negedge clk);
        nChecks++; if (outValid2 !== 1'b0) $display("[TB] FAIL basic_valid_e1: got %b want 0", outValid2); else nPass++;
        @(negedge clk);
        nChecks++; if (outValid2 !== 1'b1) $display("[TB] FAIL basic_valid_e2: got %b want 1", outValid2); else nPass++;
        recv(0, 0);
        nChecks++; if (rxCount !== 4) $display("[TB] FAIL basic_count: got %0d want 4", rxCount); else nPass++;
        for (int k = 0; k < 4; k++) begin
            nChecks++; if (rxData[k] !== cWords[k]) $display("[TB] FAIL basic_word%0d: got %h want %h", k, rxData[k], cWords[k]); else nPass++;
            nChecks++; if (rxIdx[k] !== 2'(k) || rxLast[k] !== (k == 3)) $display("[TB] FAIL basic_idx%0d: got idx=%0d last=%b want idx=%0d last=%b", k, rxIdx[k], rxLast[k], k, (k == 3)); else nPass++;
        end
        nChecks++; if (inReady2 !== 1'b0) $display("[TB] FAIL basic_ready_e5: got %b want 0", inReady2); else nPass++;
        @(negedge clk);
        nChecks++; if (inReady2 !== 1'b1) $display("[TB] FAIL basic_ready_e6: got %b want 1", inReady2); else nPass++;
        nChecks++; if (outValid2 !== 1'b0 || outData2 !== 32'h0) $display("[TB] FAIL basic_idle_out: got vld=%b data=%h want 0/0", outValid2, outData2); else nPass++;
    endtask

    task automatic test_backpressure;
        logic [127:0] r;
        r = rand128();
        sel3 = 1'b0;
        outReady = 1'b1;
        sh2 = pack2(r, r ^ C);
        cv2 = 1'b1;
        @(negedge clk);
        cv2 = 1'b0;
        recv(1, 3);
        nChecks++; if (rxHoldBad !== 1'b0) $display("[TB] FAIL bp_hold_stable: got %b want 0", rxHoldBad); else nPass++;
        nChecks++; if (rxCount !== 4) $display("[TB] FAIL bp_count: got %0d want 4", rxCount); else nPass++;
        for (int k = 0; k < 4; k++) begin
            nChecks++; if (rxData[k] !== cWords[k] || rxIdx[k] !== 2'(k)) $display("[TB] FAIL bp_word%0d: got %h idx %0d want %h idx %0d", k, rxData[k], rxIdx[k], cWords[k], k); else nPass++;
        end
        @(negedge clk);
    endtask

    task automatic test_drop;
        logic [127:0] r;
        r = rand128();
        sel3 = 1'b0;
        outReady = 1'b0;
        sh2 = pack2(r, r ^ C);
        cv2 = 1'b1;
        @(negedge clk);
        sh2 = pack2(r, ~(r ^ C));
        @(negedge clk);
        cv2 = 1'b0;
        @(negedge clk);
        cv2 = 1'b1;
        @(negedge clk);
        cv2 = 1'b0;
        nChecks++; if (dropCnt2 !== 8'd2) $display("[TB] FAIL drop_two: got %0d want 2", dropCnt2); else nPass++;
        recv(0, 0);
        for (int k = 0; k < 4; k++) begin
            nChecks++; if (rxData[k] !== cWords[k]) $display("[TB] FAIL drop_word%0d: got %h want %h", k, rxData[k], cWords[k]); else nPass++;
        end
        @(negedge clk);
        outReady = 1'b0;
        sh2 = pack2(r, r ^ C);
        cv2 = 1'b1;
        @(negedge clk);
        sh2 = '1;
        repeat (300) @(negedge clk);
        cv2 = 1'b0;
        nChecks++; if (dropCnt2 !== 8'd255) $display("[TB] FAIL drop_saturate: got %0d want 255", dropCnt2); else nPass++;
        recv(0, 0);
        nChecks++; if (rxData[3] !== cWords[3] || rxData[0] !== cWords[0]) $display("[TB] FAIL drop_sat_data: got %h/%h want %h/%h", rxData[0], rxData[3], cWords[0], cWords[3]); else nPass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_acc;
        logic [127:0] r;
        r = rand128();
        sel3 = 1'b0;
        outReady = 1'b1;
        sh2 = pack2(r, r ^ C);
        cv2 = 1'b1;
        @(negedge clk);
        cv2 = 1'b0;
        #2 rst = 1'b1;
        #1;
        nChecks++; if (inReady2 !== 1'b1 || outValid2 !== 1'b0) $display("[TB] FAIL rstacc_hs: got rdy=%b vld=%b want 1/0", inReady2, outValid2); else nPass++;
        nChecks++; if (outData2 !== 32'h0 || outIdx2 !== 2'd0 || outLast2 !== 1'b0) $display("[TB] FAIL rstacc_out: got %h/%0d/%b want 0/0/0", outData2, outIdx2, outLast2); else nPass++;
        nChecks++; if (dropCnt2 !== 8'd0) $display("[TB] FAIL rstacc_drop: got %0d want 0", dropCnt2); else nPass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        nChecks++; if (outValid2 !== 1'b0 || inReady2 !== 1'b1) $display("[TB] FAIL rstacc_discard: got vld=%b rdy=%b want 0/1", outValid2, inReady2); else nPass++;
        r = rand128();
        sh2 = pack2(r, r ^ C);
        cv2 = 1'b1;
        @(negedge clk);
        cv2 = 1'b0;
        recv(0, 0);
        for (int k = 0; k < 4; k++) begin
            nChecks++; if (rxData[k] !== cWords[k]) $display("[TB] FAIL rstacc_word%0d: got %h want %h", k, rxData[k], cWords[k]); else nPass++;
        end
        @(negedge clk);
    endtask

    task automatic test_d3;
        logic [127:0] r1, r2;
        r1 = rand128();
        r2 = rand128();
        sel3 = 1'b1;
        outReady = 1'b1;
        sh3 = pack3(r1, r2, r1 ^ r2 ^ C);
        cv3 = 1'b1;
        @(negedge clk);
        cv3 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        nChecks++; if (outValid3 !== 1'b0) $display("[TB] FAIL d3_valid_e2: got %b want 0", outValid3); else nPass++;
        @(negedge clk);
        nChecks++; if (outValid3 !== 1'b1) $display("[TB] FAIL d3_valid_e3: got %b want 1", outValid3); else nPass++;
        recv(0, 0);
        for (int k = 0; k < 4; k++) begin
            nChecks++; if (rxData[k] !== cWords[k] || rxIdx[k] !== 2'(k)) $display("[TB] FAIL d3_word%0d: got %h idx %0d want %h idx %0d", k, rxData[k], rxIdx[k], cWords[k], k); else nPass++;
        end
        @(negedge clk);
        sh3 = '0;
        cv3 = 1'b1;
        @(negedge clk);
        cv3 = 1'b0;
        recv(0, 0);
        nChecks++; if (rxCount !== 4) $display("[TB] FAIL d3_zero_count: got %0d want 4", rxCount); else nPass++;
        for (int k = 0; k < 4; k++) begin
            nChecks++; if (rxData[k] !== 32'h0) $display("[TB] FAIL d3_zero_word%0d: got %h want 00000000", k, rxData[k]); else nPass++;
        end
        @(negedge clk);
        nChecks++; if (inReady3 !== 1'b1 || dropCnt3 !== 8'd0) $display("[TB] FAIL d3_end: got rdy=%b drop=%0d want 1/0", inReady3, dropCnt3); else nPass++;
        sel3 = 1'b0;
    endtask

    // t counts negedges; the posedge after negedge t is edge E0+t.
    task automatic runB2B(input int secondT, output logic readyAtSecond);
        logic [127:0] r, r2;
        r = rand128();
        r2 = rand128();
        sel3 = 1'b0;
        outReady = 1'b1;
        rxCount = 0;
        readyAtSecond = 1'bx;
        for (int t = 0; t < 18; t++) begin
            if (t > 0) @(negedge clk);
            if (outValid2 === 1'b1 && rxCount < 8) begin
                rxData[rxCount] = outData2;
                rxIdx[rxCount] = outIdx2;
                rxCount++;
            end
            if (t == secondT) readyAtSecond = inReady2;
            cv2 = (t == 0) || (t == secondT);
            sh2 = (t == 0) ? pack2(r, r ^ C) : pack2(r2, r2 ^ ~C);
        end
        cv2 = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic rdy;
        runB2B(7, rdy);
        nChecks++; if (rdy !== 1'b1) $display("[TB] FAIL b2b_ready_at_e7: got %b want 1", rdy); else nPass++;
        nChecks++; if (rxCount !== 8) $display("[TB] FAIL b2b_count: got %0d want 8", rxCount); else nPass++;
        for (int k = 0; k < 4; k++) begin
            nChecks++; if (rxData[k] !== cWords[k]) $display("[TB] FAIL b2b_first%0d: got %h want %h", k, rxData[k], cWords[k]); else nPass++;
            nChecks++; if (rxData[k+4] !== ~cWords[k] || rxIdx[k+4] !== 2'(k)) $display("[TB] FAIL b2b_second%0d: got %h want %h", k, rxData[k+4], ~cWords[k]); else nPass++;
        end
        nChecks++; if (dropCnt2 !== 8'd0) $display("[TB] FAIL b2b_drop: got %0d want 0", dropCnt2); else nPass++;
        runB2B(6, rdy);
        nChecks++; if (rdy !== 1'b0) $display("[TB] FAIL early_ready_at_e6: got %b want 0", rdy); else nPass++;
        nChecks++; if (rxCount !== 4) $display("[TB] FAIL early_count: got %0d want 4", rxCount); else nPass++;
        nChecks++; if (rxData[3] !== cWords[3]) $display("[TB] FAIL early_word3: got %h want %h", rxData[3], cWords[3]); else nPass++;
        nChecks++; if (dropCnt2 !== 8'd1) $display("[TB] FAIL early_drop: got %0d want 1", dropCnt2); else nPass++;
        nChecks++; if (inReady2 !== 1'b1) $display("[TB] FAIL early_idle: got %b want 1", inReady2); else nPass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_drop();
        test_reset_mid_acc();
        test_d3();
        test_back_to_back();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
